// File: rtl/stream_muxnx1.sv
// N-input, one-output valid/ready stream mux with round-robin arbitration and a registered output beat.
// Define MUX_PKT_LOCK_EN to hold the grant on one channel from the first beat of a packet until its in_last beat.
module stream_muxnx1 #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic             can_load;
  logic             have_req;
  logic             xfer;
  logic             ptr_load;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] grant_inc;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W:0]   rr_sum;
  logic [SEL_W-1:0] rr_idx;
  logic [WIDTH-1:0] ch_data [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign can_load = !out_valid || out_ready;

  // Search from ptr upward; the sum is one bit wider so the wrap also works for non-power-of-two counts.
  always_comb begin
    rr_grant = ptr;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      rr_sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (rr_sum >= (SEL_W+1)'(CHANNELS)) begin
        rr_sum = rr_sum - (SEL_W+1)'(CHANNELS);
      end
      rr_idx = rr_sum[SEL_W-1:0];
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  assign grant_inc = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;

`ifdef MUX_PKT_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;

  // While locked, other channels stay blocked even if the locked channel has nothing to send.
  assign grant    = lock ? lock_ch : rr_grant;
  assign have_req = lock ? in_valid[lock_ch] : rr_found;
  assign ptr_load = xfer && in_last[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      lock <= !in_last[grant];
      if (!in_last[grant]) begin
        lock_ch <= grant;
      end
    end
  end
`else
  assign grant    = rr_grant;
  assign have_req = rr_found;
  assign ptr_load = xfer;
`endif

  assign xfer = can_load && have_req;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (ptr_load) begin
      ptr <= grant_inc;
    end
  end

  // A load and a drain on the same edge keep out_valid high; a drain alone leaves the payload as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[grant];
      out_last  <= in_last[grant];
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_muxnx1.sv
// Self-checking bench for stream_muxnx1 (CHANNELS=4, WIDTH=8): directed scenarios plus a randomized run
// against a spec-level reference model; honours MUX_PKT_LOCK_EN when defined.
module tb_stream_muxnx1;

  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: round-robin pointer, optional packet lock and the single output beat.
  int         m_ptr;
  bit         m_lock;
  int         m_lock_ch;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] m_sel;
  int         last_ch;

  stream_muxnx1 #(.WIDTH(8), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_cmp++;
    assert (obs === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expected);
    end
  endtask

  task automatic modelReset();
    m_ptr     = 0;
    m_lock    = 1'b0;
    m_lock_ch = 0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_last    = 1'b0;
    m_sel     = 2'd0;
    last_ch   = -1;
  endtask

  function automatic void modelGrant(output bit found, output int g);
    found = 1'b0;
    g     = 0;
`ifdef MUX_PKT_LOCK_EN
    if (m_lock) begin
      g     = m_lock_ch;
      found = in_valid[m_lock_ch];
      return;
    end
`endif
    for (int k = 0; k < CH; k++) begin
      if (!found && in_valid[(m_ptr + k) % CH]) begin
        found = 1'b1;
        g     = (m_ptr + k) % CH;
      end
    end
  endfunction

  // One clock: check in_ready before the edge, advance the model on the edge, check the output stage after it.
  task automatic applyStimulus();
    bit         found;
    int         g;
    bit         can_load;
    logic [3:0] exp_ready;
    #2;
    modelGrant(found, g);
    can_load  = !m_valid || out_ready;
    exp_ready = (can_load && found) ? 4'(1 << g) : 4'b0000;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    last_ch = -1;
    if (can_load && found) begin
      m_valid = 1'b1;
      m_data  = in_data[g*8 +: 8];
      m_last  = in_last[g];
      m_sel   = 2'(g);
      last_ch = g;
`ifdef MUX_PKT_LOCK_EN
      if (in_last[g]) begin
        m_lock = 1'b0;
        m_ptr  = (g + 1) % CH;
      end else begin
        m_lock    = 1'b1;
        m_lock_ch = g;
      end
`else
      m_ptr = (g + 1) % CH;
`endif
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    checkOutput("out_stage", 32'({out_valid, out_last, out_sel, out_data}),
                32'({m_valid, m_last, m_sel, m_data}));
  endtask

  initial begin
    int rr_seq[6] = '{0, 1, 2, 3, 0, 1};
`ifdef MUX_PKT_LOCK_EN
    int pk_seq[4] = '{1, 1, 1, 2};
`else
    int pk_seq[4] = '{1, 2, 0, 1};
`endif
    int b;

    in_data   = 32'h0;
    in_valid  = 4'b0000;
    in_last   = 4'b1111;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_out", 32'({out_valid, out_last, out_sel, out_data}), 32'h0);
    checkOutput("reset_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;

    // Reset mid-transfer: a held beat is discarded asynchronously
    in_valid = 4'b0001;
    in_data[7:0] = 8'h77;
    applyStimulus();
    in_valid = 4'b0000;
    applyStimulus();
    checkOutput("t1_held_valid", 32'(out_valid), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    checkOutput("t1_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t1_rst_data", 32'(out_data), 32'h0);
    checkOutput("t1_rst_sel", 32'(out_sel), 32'd0);
    checkOutput("t1_rst_last", 32'(out_last), 32'd0);
    checkOutput("t1_rst_ready", 32'(in_ready), 32'h0);
    modelReset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin across all four channels
    in_data   = 32'h13121110;
    in_last   = 4'b1111;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("t3_rr_sel", 32'(out_sel), 32'(rr_seq[i]));
      checkOutput("t3_rr_data", 32'(out_data), 32'(8'h10 + rr_seq[i]));
    end

    // Single beat from channel 2
    in_valid = 4'b0100;
    in_data[23:16] = 8'hA5;
    #2;
    checkOutput("t2_ready", 32'(in_ready), 32'h4);
    applyStimulus();
    checkOutput("t2_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_data", 32'(out_data), 32'hA5);
    checkOutput("t2_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b0000;
    applyStimulus();
    checkOutput("t2_drain", 32'(out_valid), 32'd0);

    // Backpressure while holding 8'h3C from channel 3
    in_valid = 4'b1000;
    in_data[31:24] = 8'h3C;
    applyStimulus();
    out_ready = 1'b0;
    in_valid  = 4'b1001;
    in_data[7:0]   = 8'h40;
    in_data[31:24] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("t4_hold_ready", 32'(in_ready), 32'h0);
      applyStimulus();
      checkOutput("t4_hold_data", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("t4_rel_sel", 32'(out_sel), 32'd0);
    checkOutput("t4_rel_data", 32'(out_data), 32'h40);
    applyStimulus();
    checkOutput("t4_next_sel", 32'(out_sel), 32'd3);
    checkOutput("t4_next_data", 32'(out_data), 32'h43);
    in_valid = 4'b0000;
    applyStimulus();

    // Packet of three beats on channel 1 competing with channels 0 and 2
    in_valid = 4'b0001;
    in_data[7:0] = 8'hA0;
    applyStimulus();
    in_data[15:8]  = 8'h01;
    in_data[23:16] = 8'hC0;
    in_last  = 4'b1101;
    in_valid = 4'b0111;
    b = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("t5_pkt_sel", 32'(out_sel), 32'(pk_seq[i]));
      if (last_ch == 1) begin
        b++;
        if (b == 3) begin
          in_valid[1] = 1'b0;
        end else begin
          in_data[15:8] = 8'(b + 1);
          in_last[1]    = (b == 2);
        end
      end
    end
    in_valid = 4'b0000;
    in_last  = 4'b1111;
    applyStimulus();

`ifdef MUX_PKT_LOCK_EN
    // Locked channel goes idle mid-packet; channel 0 must wait
    in_valid = 4'b0010;
    in_data[15:8] = 8'h51;
    in_last = 4'b1101;
    applyStimulus();
    in_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #2;
      checkOutput("t6_gap_ready0", 32'(in_ready[0]), 32'd0);
      applyStimulus();
    end
    in_valid = 4'b0011;
    in_data[15:8] = 8'h52;
    in_last = 4'b1111;
    applyStimulus();
    checkOutput("t6_resume_sel", 32'(out_sel), 32'd1);
    checkOutput("t6_resume_data", 32'(out_data), 32'h52);
    in_valid = 4'b0001;
    applyStimulus();
    checkOutput("t6_after_sel", 32'(out_sel), 32'd0);
    in_valid = 4'b0000;
    applyStimulus();
`endif

    // Randomized traffic with random backpressure against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
